// File: rtl/result_sel_pipe.sv
// rtl/result_sel_pipe.sv - NSRC-way result selector with registered output and 2-entry skid buffer
module result_sel_pipe #(
    parameter int N     = 16,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC*N-1:0] src_data,
    input  logic [SEL_W-1:0]  sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out_data,
    output logic [SEL_W-1:0]  out_src,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     skid_data;
    logic [SEL_W-1:0] skid_src;
    logic             skid_err;

    logic [N-1:0]     cap_data;
    logic             cap_err;

    // Select the addressed channel; an index with no channel behind it yields 0 and flags an error
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = src_data[k*N +: N];
                cap_err  = 1'b0;
            end
        end
    end

    // Occupancy FSM: main register drives the outputs, skid absorbs one extra entry while writeback stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_src  <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        out_data  <= cap_data;
                        out_src   <= sel;
                        out_err   <= cap_err;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        out_data <= cap_data;
                        out_src  <= sel;
                        out_err  <= cap_err;
                    end else if (in_valid) begin
                        skid_data <= cap_data;
                        skid_src  <= sel;
                        skid_err  <= cap_err;
                        in_ready  <= 1'b0;
                        state     <= FULL;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_data <= skid_data;
                        out_src  <= skid_src;
                        out_err  <= skid_err;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_sel_pipe.sv
// tb/tb_result_sel_pipe.sv - scoreboard testbench for result_sel_pipe
module tb_result_sel_pipe;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] src_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] b_src_data;
    logic [1:0]  b_sel;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_src;
    logic        b_out_err;
    logic        b_out_valid;
    logic        b_out_ready;

    exp_t q[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    result_sel_pipe #(.N(16), .NSRC(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_src(out_src), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    result_sel_pipe #(.N(16), .NSRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .src_data(b_src_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_src(b_out_src), .out_err(b_out_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the NSRC=4 instance: every completed output transfer pops one expected entry
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data 0x%0h src %0d with empty scoreboard", out_data, out_src);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_src", 32'(out_src), 32'(e.src));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Monitor for the NSRC=3 instance
    always @(negedge clk) begin
        if (!rst && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out3: got data 0x%0h src %0d", b_out_data, b_out_src);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("out3_data", 32'(b_out_data), 32'(e.data));
                check("out3_src", 32'(b_out_src), 32'(e.src));
                check("out3_err", 32'(b_out_err), 32'(e.err));
            end
        end
    end

    // Offer one transaction to the 4-source instance, waiting (bounded) for in_ready
    task automatic offer(input logic [1:0] s, input logic [15:0] d, input logic e);
        bit ok = 0;
        sel      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL offer_timeout: in_ready stuck low for sel %0d", s);
        end else begin
            @(posedge clk);
            q.push_back('{data: d, src: s, err: e});
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t exp_tab [4];
        exp_tab[0] = '{data: 16'd20,   src: 2'd0, err: 1'b0};
        exp_tab[1] = '{data: 16'd10,   src: 2'd1, err: 1'b0};
        exp_tab[2] = '{data: 16'hBEEF, src: 2'd2, err: 1'b0};
        exp_tab[3] = '{data: 16'hFFFF, src: 2'd3, err: 1'b0};

        src_data    = 64'hFFFF_BEEF_000A_0014;
        sel         = 2'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_src_data  = 48'h3333_2222_1111;
        b_sel       = 2'd0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        // 1: reset with random inputs
        repeat (2) begin
            @(posedge clk);
            #1;
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // 2: single transaction, sel=1
        offer(2'd1, 16'd10, 1'b0);
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_data", 32'(out_data), 32'd10);
        @(negedge clk);
        check("t2_out_valid_after", 32'(out_valid), 32'd0);

        // 3: fill to FULL while stalled, then drain
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer(2'd0, 16'd20, 1'b0);
        offer(2'd2, 16'hBEEF, 1'b0);
        @(negedge clk);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_held_data", 32'(out_data), 32'd20);
        @(negedge clk);
        check("t3_held_data2", 32'(out_data), 32'd20);
        check("t3_held_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_drain0", 32'(out_data), 32'd20);
        @(negedge clk);
        check("t3_drain1", 32'(out_data), 32'hBEEF);
        check("t3_in_ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4: NSRC=3 instance, valid index then out-of-range index
        @(posedge clk);
        #1;
        b_sel      = 2'd2;
        b_in_valid = 1'b1;
        @(negedge clk);
        check("t4_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        qb.push_back('{data: 16'h3333, src: 2'd2, err: 1'b0});
        #1;
        b_sel = 2'd3;
        @(negedge clk);
        check("t4_in_ready2", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        qb.push_back('{data: 16'h0000, src: 2'd3, err: 1'b1});
        #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t4_err_flag", 32'(b_out_err), 32'd1);
        @(negedge clk);
        check("t4_drained", 32'(b_out_valid), 32'd0);

        // 5: full-throughput stream of 8
        @(posedge clk);
        #1;
        n_out     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i % 4);
            @(negedge clk);
            check("t5_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) check("t5_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            q.push_back(exp_tab[i % 4]);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_last_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("t5_idle", 32'(out_valid), 32'd0);
        check("t5_count", 32'(n_out), 32'd8);

        // 6: reset while FULL drops both held entries
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        offer(2'd3, 16'hFFFF, 1'b0);
        offer(2'd1, 16'd10, 1'b0);
        @(negedge clk);
        check("t6_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_out_data", 32'(out_data), 32'd0);
        repeat (3) @(negedge clk);

        check("sb_empty", 32'(q.size()), 32'd0);
        check("sb3_empty", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
